control_sequencer: RTL
======================

// Module: control_sequencer
// PURPOSE
//  Hardwired control unit for the mini CPU datapath: steps T0..T7 and emits the control word.
//  It replaces bench-driven per-state control for fetch, ALU reg/imm, ld/st, branch and halt.
//  Decodes IR opcode after fetch, stalls on a memory-ready handshake, times out hung accesses.
// PARAMETERS
//  IR_W        32   instruction width; opcode = ir[IR_W-1 -: OPC_W]
//  OPC_W       5    opcode width
//  TMO_CYC     15   max cycles waiting mem_ready before abort (>=1)
// PORTS
//  Clock          in   1     single clock, all state on posedge
//  clear          in   1     asynchronous, active-high reset
//  ir             in   IR_W  IR register contents (valid from T3)
//  branchCompare  in   1     CON FF output from datapath
//  mem_ready      in   1     RAM/MDR access complete this cycle
//  ctrl           out  CW_W  control word; bit indices in cpu_ctrl_pkg
//  alu_op         out  OPC_W ALU operation select
//  tstep          out  3     current T-step (debug/bench visibility)
//  halted         out  1     core stopped (halt opcode or timeout)
//  mem_err        out  1     sticky: memory handshake timed out
//  illegal        out  1     one-cycle pulse: undefined opcode decoded
// BEHAVIOUR
//  - States: RST, T0..T7, HALT. clear -> RST async; all outputs 0, tstep=0.
//  - RST -> T0 next edge. Outputs decoded from registered state + latched opcode (Moore); valid same cycle.
//  - Fetch: T0 PCout MARin IncPC Zin | T1 Zlowout PCin Read MDRin | T2 MDRout IRin.
//  - T3: latch opcode from ir; class lookup chooses path; alu_op=opcode for ALU classes, ADD otherwise.
//  - ALU reg (00000-01011): T3 Grb Rout Yin | T4 Grc Rout Zin | T5 Zlowout Gra Rin -> T0.
//  - ALU imm (01100-01110): T3 Grb Rout Yin | T4 Cout Zin | T5 Zlowout Gra Rin -> T0.
//  - ld (10000): T3 Grb BAOut Yin | T4 Cout Zin | T5 Zlowout MARin | T6 Read MDRin | T7 MDRout Gra Rin -> T0.
//  - st (10001): T3-T5 as ld | T6 Gra Rout MDRin | T7 Write -> T0.
//  - br (10010): T3 Gra Rout CONin | T4 PCout Yin | T5 Cout Zin | T6 Zlowout, PCin only if branchCompare=1 -> T0.
//  - halt (11011): T3 -> HALT; halted=1; all ctrl 0; remains until clear.
//  - Undefined opcode: illegal pulses in T3, no datapath enables, T3 -> T0 (treated as nop).
//  - Wait steps (T1, ld T6, st T7): state held while mem_ready=0; Read/Write and enables stay asserted.
//    Advance on first cycle mem_ready=1. Zero-wait (mem_ready already 1) costs no extra cycle.
//  - Timeout: wait counter resets on entering wait step; at TMO_CYC consecutive stalled cycles -> HALT,
//    mem_err=1 (sticky until clear), Read/Write dropped same edge.
//  - clear mid-instruction: immediate abort, no partial write; mem_err/halted cleared.
//  - Exactly one bus driver (*out/Rout/Cout/BAOut) per step; one-hot enforced by table construction.
// CONFIGURATION
//  SINGLE_STEP_EN defined: adds input step_req (1b); state advances only on edges where step_req=1
//    (and mem_ready for wait steps); ctrl held while waiting; timeout counter frozen while step_req=0.
//  Undefined: no step_req port; sequencer free-runs every cycle.
// STRUCTURE
//  cpu_ctrl_pkg: CW_W, ctrl bit index localparams, opcode constants, class enum
//    (CLS_ALUR, CLS_ALUI, CLS_LD, CLS_ST, CLS_BR, CLS_HALT, CLS_ILL), state encodings.
//  Sub-module ctrl_word_rom: combinational (state, class, branchCompare) -> ctrl; sequencer holds FSM,
//  opcode latch, wait/timeout counter and flags.
// TESTING
//  addi R3,R4,15 (ir=0x61A0000F), mem_ready=1 -> T0..T5 in 6 cycles, T4 has Cout+Zin, alu_op=01100.
//  ld, mem_ready low 3 cycles at T6 -> T6 held 4 cycles with Read+MDRin, then T7 MDRout Gra Rin.
//  br with branchCompare=1 vs 0 -> T6 PCin asserted vs not; both return to T0 next cycle.
//  mem_ready stuck 0 in T1, TMO_CYC=15 -> HALT after 15 stall cycles, mem_err=1, Read=0.
//  opcode 11111 -> illegal pulse in T3, no enables, T0 next; opcode 11011 -> halted=1 until clear.
//  clear asserted mid-st T7 -> ctrl=0 asynchronously (Write drops before next edge), RST then T0.

Source files
------------

// File: rtl/control_sequencer_pkg.sv
// rtl/control_sequencer_pkg.sv - control word layout, opcodes, instruction classes and FSM states
package control_sequencer_pkg;

  localparam int OPC_W = 5;
  localparam int CW_W  = 20;

  localparam int CW_PC_OUT   = 0;
  localparam int CW_MAR_IN   = 1;
  localparam int CW_INC_PC   = 2;
  localparam int CW_Z_IN     = 3;
  localparam int CW_ZLOW_OUT = 4;
  localparam int CW_PC_IN    = 5;
  localparam int CW_READ     = 6;
  localparam int CW_MDR_IN   = 7;
  localparam int CW_MDR_OUT  = 8;
  localparam int CW_IR_IN    = 9;
  localparam int CW_GRA      = 10;
  localparam int CW_GRB      = 11;
  localparam int CW_GRC      = 12;
  localparam int CW_R_OUT    = 13;
  localparam int CW_Y_IN     = 14;
  localparam int CW_R_IN     = 15;
  localparam int CW_C_OUT    = 16;
  localparam int CW_BA_OUT   = 17;
  localparam int CW_CON_IN   = 18;
  localparam int CW_WRITE    = 19;

  localparam logic [OPC_W-1:0] OPC_ADD        = 5'b00000;
  localparam logic [OPC_W-1:0] OPC_ALUR_LAST  = 5'b01011;
  localparam logic [OPC_W-1:0] OPC_ALUI_FIRST = 5'b01100;
  localparam logic [OPC_W-1:0] OPC_ALUI_LAST  = 5'b01110;
  localparam logic [OPC_W-1:0] OPC_LD         = 5'b10000;
  localparam logic [OPC_W-1:0] OPC_ST         = 5'b10001;
  localparam logic [OPC_W-1:0] OPC_BR         = 5'b10010;
  localparam logic [OPC_W-1:0] OPC_HALT       = 5'b11011;

  typedef enum logic [2:0] {
    CLS_ALUR, CLS_ALUI, CLS_LD, CLS_ST, CLS_BR, CLS_HALT, CLS_ILL
  } cls_e;

  typedef enum logic [3:0] {
    ST_RST, ST_T0, ST_T1, ST_T2, ST_T3, ST_T4, ST_T5, ST_T6, ST_T7, ST_HALT
  } state_e;

  function automatic cls_e opc_class(input logic [OPC_W-1:0] opc);
    cls_e c;
    if (opc <= OPC_ALUR_LAST) begin
      c = CLS_ALUR;
    end else if (opc >= OPC_ALUI_FIRST && opc <= OPC_ALUI_LAST) begin
      c = CLS_ALUI;
    end else begin
      case (opc)
        OPC_LD:   c = CLS_LD;
        OPC_ST:   c = CLS_ST;
        OPC_BR:   c = CLS_BR;
        OPC_HALT: c = CLS_HALT;
        default:  c = CLS_ILL;
      endcase
    end
    return c;
  endfunction

  // RST and HALT report step 0 so the debug view never shows a stale step
  function automatic logic [2:0] state_tstep(input state_e s);
    logic [2:0] t;
    case (s)
      ST_T1:   t = 3'd1;
      ST_T2:   t = 3'd2;
      ST_T3:   t = 3'd3;
      ST_T4:   t = 3'd4;
      ST_T5:   t = 3'd5;
      ST_T6:   t = 3'd6;
      ST_T7:   t = 3'd7;
      default: t = 3'd0;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/control_sequencer_if.sv
// rtl/control_sequencer_if.sv - sequencer/datapath signal bundle; step_req exists only with SINGLE_STEP_EN
interface control_sequencer_if #(parameter int IR_W = 32);
  import control_sequencer_pkg::*;

  logic [IR_W-1:0]  ir;
  logic             branch_compare;
  logic             mem_ready;
`ifdef SINGLE_STEP_EN
  logic             step_req;
`endif
  logic [CW_W-1:0]  ctrl;
  logic [OPC_W-1:0] alu_op;
  logic [2:0]       tstep;
  logic             halted;
  logic             mem_err;
  logic             illegal;

  modport master (
`ifdef SINGLE_STEP_EN
    input  step_req,
`endif
    input  ir, branch_compare, mem_ready,
    output ctrl, alu_op, tstep, halted, mem_err, illegal
  );

  modport slave (
`ifdef SINGLE_STEP_EN
    output step_req,
`endif
    output ir, branch_compare, mem_ready,
    input  ctrl, alu_op, tstep, halted, mem_err, illegal
  );

endinterface

// File: rtl/control_sequencer_ctrl_word_rom.sv
// rtl/control_sequencer_ctrl_word_rom.sv - combinational (state, class, branch_compare) to control word table
module control_sequencer_ctrl_word_rom
  import control_sequencer_pkg::*;
(
  input  state_e          state,
  input  cls_e            cls,
  input  logic            branch_compare,
  output logic [CW_W-1:0] ctrl
);

  // Each row drives exactly one source onto the bus
  always_comb begin
    ctrl = '0;
    case (state)
      ST_T0: begin
        ctrl[CW_PC_OUT] = 1'b1;
        ctrl[CW_MAR_IN] = 1'b1;
        ctrl[CW_INC_PC] = 1'b1;
        ctrl[CW_Z_IN]   = 1'b1;
      end
      ST_T1: begin
        ctrl[CW_ZLOW_OUT] = 1'b1;
        ctrl[CW_PC_IN]    = 1'b1;
        ctrl[CW_READ]     = 1'b1;
        ctrl[CW_MDR_IN]   = 1'b1;
      end
      ST_T2: begin
        ctrl[CW_MDR_OUT] = 1'b1;
        ctrl[CW_IR_IN]   = 1'b1;
      end
      ST_T3: begin
        case (cls)
          CLS_ALUR, CLS_ALUI: begin
            ctrl[CW_GRB]   = 1'b1;
            ctrl[CW_R_OUT] = 1'b1;
            ctrl[CW_Y_IN]  = 1'b1;
          end
          CLS_LD, CLS_ST: begin
            ctrl[CW_GRB]    = 1'b1;
            ctrl[CW_BA_OUT] = 1'b1;
            ctrl[CW_Y_IN]   = 1'b1;
          end
          CLS_BR: begin
            ctrl[CW_GRA]    = 1'b1;
            ctrl[CW_R_OUT]  = 1'b1;
            ctrl[CW_CON_IN] = 1'b1;
          end
          default: ;
        endcase
      end
      ST_T4: begin
        case (cls)
          CLS_ALUR: begin
            ctrl[CW_GRC]   = 1'b1;
            ctrl[CW_R_OUT] = 1'b1;
            ctrl[CW_Z_IN]  = 1'b1;
          end
          CLS_ALUI, CLS_LD, CLS_ST: begin
            ctrl[CW_C_OUT] = 1'b1;
            ctrl[CW_Z_IN]  = 1'b1;
          end
          CLS_BR: begin
            ctrl[CW_PC_OUT] = 1'b1;
            ctrl[CW_Y_IN]   = 1'b1;
          end
          default: ;
        endcase
      end
      ST_T5: begin
        case (cls)
          CLS_ALUR, CLS_ALUI: begin
            ctrl[CW_ZLOW_OUT] = 1'b1;
            ctrl[CW_GRA]      = 1'b1;
            ctrl[CW_R_IN]     = 1'b1;
          end
          CLS_LD, CLS_ST: begin
            ctrl[CW_ZLOW_OUT] = 1'b1;
            ctrl[CW_MAR_IN]   = 1'b1;
          end
          CLS_BR: begin
            ctrl[CW_C_OUT] = 1'b1;
            ctrl[CW_Z_IN]  = 1'b1;
          end
          default: ;
        endcase
      end
      ST_T6: begin
        case (cls)
          CLS_LD: begin
            ctrl[CW_READ]   = 1'b1;
            ctrl[CW_MDR_IN] = 1'b1;
          end
          CLS_ST: begin
            ctrl[CW_GRA]    = 1'b1;
            ctrl[CW_R_OUT]  = 1'b1;
            ctrl[CW_MDR_IN] = 1'b1;
          end
          CLS_BR: begin
            ctrl[CW_ZLOW_OUT] = 1'b1;
            ctrl[CW_PC_IN]    = branch_compare;
          end
          default: ;
        endcase
      end
      ST_T7: begin
        case (cls)
          CLS_LD: begin
            ctrl[CW_MDR_OUT] = 1'b1;
            ctrl[CW_GRA]     = 1'b1;
            ctrl[CW_R_IN]    = 1'b1;
          end
          CLS_ST: ctrl[CW_WRITE] = 1'b1;
          default: ;
        endcase
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/control_sequencer.sv
// rtl/control_sequencer.sv - T0..T7 hardwired control FSM with memory wait/timeout; SINGLE_STEP_EN gates advance on step_req
module control_sequencer
  import control_sequencer_pkg::*;
#(
  parameter int IR_W    = 32,
  parameter int TMO_CYC = 15
) (
  input  logic                clk,
  input  logic                rst,
  control_sequencer_if.master bus
);

  localparam int CNT_W = $clog2(TMO_CYC + 1);

  state_e           state;
  state_e           state_nxt;
  logic [OPC_W-1:0] opc_q;
  logic [OPC_W-1:0] opc_cur;
  cls_e             cls;
  logic [CNT_W-1:0] wait_cnt;
  logic             mem_err_q;
  logic             advance;
  logic             is_wait;
  logic             stall;
  logic             timeout;

`ifdef SINGLE_STEP_EN
  assign advance = bus.step_req;
`else
  assign advance = 1'b1;
`endif

  // IR only becomes valid in T3, so T3 decodes the live opcode and later steps use the latched copy
  assign opc_cur = (state == ST_T3) ? bus.ir[IR_W-1 -: OPC_W] : opc_q;
  assign cls     = opc_class(opc_cur);

  assign is_wait = (state == ST_T1) ||
                   (state == ST_T6 && cls == CLS_LD) ||
                   (state == ST_T7 && cls == CLS_ST);
  assign stall   = is_wait && !bus.mem_ready;
  assign timeout = stall && (wait_cnt == CNT_W'(TMO_CYC - 1));

  always_comb begin
    state_nxt = state;
    if (advance) begin
      if (timeout) begin
        state_nxt = ST_HALT;
      end else if (!stall) begin
        case (state)
          ST_RST: state_nxt = ST_T0;
          ST_T0:  state_nxt = ST_T1;
          ST_T1:  state_nxt = ST_T2;
          ST_T2:  state_nxt = ST_T3;
          ST_T3: begin
            case (cls)
              CLS_HALT: state_nxt = ST_HALT;
              CLS_ILL:  state_nxt = ST_T0;
              default:  state_nxt = ST_T4;
            endcase
          end
          ST_T4:  state_nxt = ST_T5;
          ST_T5:  state_nxt = (cls == CLS_ALUR || cls == CLS_ALUI) ? ST_T0 : ST_T6;
          ST_T6:  state_nxt = (cls == CLS_BR) ? ST_T0 : ST_T7;
          ST_T7:  state_nxt = ST_T0;
          ST_HALT: state_nxt = ST_HALT;
          default: state_nxt = ST_RST;
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_RST;
      opc_q     <= '0;
      wait_cnt  <= '0;
      mem_err_q <= 1'b0;
    end else begin
      state <= state_nxt;
      if (advance) begin
        if (state == ST_T3) begin
          opc_q <= bus.ir[IR_W-1 -: OPC_W];
        end
        // Counter runs only across consecutive stalled cycles of one wait step
        if (stall && !timeout) begin
          wait_cnt <= wait_cnt + CNT_W'(1);
        end else begin
          wait_cnt <= '0;
        end
        if (timeout) begin
          mem_err_q <= 1'b1;
        end
      end
    end
  end

  control_sequencer_ctrl_word_rom u_rom (
    .state          (state),
    .cls            (cls),
    .branch_compare (bus.branch_compare),
    .ctrl           (bus.ctrl)
  );

  assign bus.alu_op  = ((cls == CLS_ALUR || cls == CLS_ALUI) && state >= ST_T3 && state <= ST_T7)
                       ? opc_cur : OPC_ADD;
  assign bus.tstep   = state_tstep(state);
  assign bus.halted  = (state == ST_HALT);
  assign bus.mem_err = mem_err_q;
  assign bus.illegal = (state == ST_T3) && (cls == CLS_ILL);

endmodule
